// File: rtl/dieu_khien_cuon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dieu_khien_cuon_pkg
// Brief    : Shared widths and direction encodings for the scroll controller.
// Revision : 1.0 - initial release
// ============================================================================
package dieu_khien_cuon_pkg;
   localparam int   POS_W   = 3;
   localparam int   NUM_POS = 8;
   localparam logic DIR_UP  = 1'b0;
   localparam logic DIR_DN  = 1'b1;
endpackage
`default_nettype wire

// File: rtl/dieu_khien_cuon_chia_tan.sv
`default_nettype none
// ============================================================================
// Module   : chia_tan
// Brief    : Prescaler; counts 0..DIV-1 while enabled, pulses on the wrap cycle.
// Revision : 1.0 - initial release
// ============================================================================
module chia_tan #(
   parameter int DIV = 25_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   output logic STEP_PULSE
);
   localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign STEP_PULSE = EN && (cnt == CNT_MAX);

   // Disabling clears the count so the next enable starts a full period.
   always_ff @(posedge CLK) begin
      if (RST || !EN) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/dieu_khien_cuon.sv
`default_nettype none
// ============================================================================
// Module   : dieu_khien_cuon
// Brief    : Scroll position source for the HELLO display (auto tick or button).
//            Define SCROLL_BOUNCE_EN for ping-pong instead of wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module dieu_khien_cuon
   import dieu_khien_cuon_pkg::*;
#(
   parameter int DIV = 25_000_000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RUN,
   input  logic             DIR,
   input  logic             STEP,
   output logic [POS_W-1:0] POS,
   output logic             TICK
);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_POS - 1);
   localparam logic [POS_W-1:0] POS_MIN = '0;

   logic             auto_step;
   logic             sync1, sync2, sync3;
   logic             btn_edge;
   logic             do_step;
   logic [POS_W-1:0] pos_next;
`ifdef SCROLL_BOUNCE_EN
   logic             dir_flag;
   logic             dir_flag_next;
`endif

   chia_tan #(
      .DIV        (DIV)
   ) u_chia_tan (
      .CLK        (CLK),
      .RST        (RST),
      .EN         (RUN),
      .STEP_PULSE (auto_step)
   );

   assign btn_edge = sync2 & ~sync3;
   assign do_step  = RUN ? auto_step : btn_edge;

   always_comb begin
      pos_next = POS;
`ifdef SCROLL_BOUNCE_EN
      dir_flag_next = dir_flag;
      if (dir_flag == DIR_UP) begin
         if (POS == POS_MAX) begin
            pos_next      = POS - 1'b1;
            dir_flag_next = DIR_DN;
         end else begin
            pos_next = POS + 1'b1;
         end
      end else begin
         if (POS == POS_MIN) begin
            pos_next      = POS + 1'b1;
            dir_flag_next = DIR_UP;
         end else begin
            pos_next = POS - 1'b1;
         end
      end
`else
      pos_next = (DIR == DIR_UP) ? POS + 1'b1 : POS - 1'b1;
`endif
   end

   // Synchronizer resets high so a button held through reset is not a press.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
         POS   <= '0;
         TICK  <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
         dir_flag <= DIR_UP;
`endif
      end else begin
         sync1 <= STEP;
         sync2 <= sync1;
         sync3 <= sync2;
         TICK  <= do_step;
         if (do_step) begin
            POS <= pos_next;
`ifdef SCROLL_BOUNCE_EN
            dir_flag <= dir_flag_next;
`endif
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dieu_khien_cuon.sv
`default_nettype none
// ============================================================================
// Module   : tb_dieu_khien_cuon
// Brief    : Table-driven self-checking bench for the scroll controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dieu_khien_cuon;
`ifdef SCROLL_BOUNCE_EN
   localparam int TB_DIV = 1;
`else
   localparam int TB_DIV = 4;
`endif

   typedef struct {
      string      name;
      logic       rst;
      logic       run;
      logic       dir;
      logic       step;
      logic [2:0] pos;
      logic       tick;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       dir = 1'b0;
   logic       step = 1'b0;
   logic [2:0] pos;
   logic       tick;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   dieu_khien_cuon #(.DIV(TB_DIV)) dut (
      .CLK  (clk),
      .RST  (rst),
      .RUN  (run),
      .DIR  (dir),
      .STEP (step),
      .POS  (pos),
      .TICK (tick)
   );

   function automatic void add(string nm, logic r, logic rn, logic d, logic s,
                               logic [2:0] p, logic t);
      vec_t v;
      v.name = nm; v.rst = r; v.run = rn; v.dir = d; v.step = s;
      v.pos = p; v.tick = t;
      vecs.push_back(v);
   endfunction

   function automatic void add_reset(logic s);
      for (int i = 0; i < 2; i++) add("reset", 1'b1, 1'b0, 1'b0, s, 3'd0, 1'b0);
      for (int i = 0; i < 3; i++) add("reset_idle", 1'b0, 1'b0, 1'b0, s, 3'd0, 1'b0);
   endfunction

   task automatic check(string nm, int idx, int act, int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s idx=%0d actual=%0d required=%0d", nm, idx, act, req);
      end
   endtask

   task automatic cycle(logic r, logic rn, logic d, logic s);
      rst = r; run = rn; dir = d; step = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int extra_ticks;

`ifdef SCROLL_BOUNCE_EN
      add_reset(1'b0);
      for (int j = 1; j <= 16; j++) begin
         int p;
         p = (j <= 7) ? j : (j <= 14) ? 14 - j : j - 14;
         add("bounce", 1'b0, 1'b1, j[0], 1'b0, 3'(p), 1'b1);
      end
`else
      // Button held through reset and after release: no step.
      add_reset(1'b1);
      for (int i = 0; i < 3; i++) add("reset_hold", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

      // Auto wrap up: change every 4th edge, 0..7 then back to 0.
      add_reset(1'b0);
      for (int j = 1; j <= 32; j++)
         add("auto_up", 1'b0, 1'b1, 1'b0, 1'b0, 3'((j / 4) % 8), (j % 4) == 0);

      // Auto down, then DIR flipped two cycles after the first step.
      add_reset(1'b0);
      for (int j = 1; j <= 3; j++) add("auto_dn", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      add("auto_dn", 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1);
      add("auto_dn", 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0);
      add("auto_dn", 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0);
      add("dir_flip", 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0);
      add("dir_flip", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);

      // Manual: 10-cycle hold then release and press again -> two steps.
      add_reset(1'b0);
      add("manual", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      add("manual", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      add("manual", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
      for (int j = 4; j <= 10; j++) add("manual_hold", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      for (int j = 11; j <= 13; j++) add("manual_low", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
      add("manual2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      add("manual2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      add("manual2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
      add("manual2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
      for (int j = 0; j < 3; j++) add("manual_low2", 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
      // Button edge lands while RUN=1 (before the auto wrap): ignored.
      add("step_in_run", 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
      add("step_in_run", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
      add("step_in_run", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
      add("step_in_run", 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
      add("step_in_run", 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);

      // RUN 1 for 3 cycles, 0, then 1: full period restarts.
      add_reset(1'b0);
      for (int j = 1; j <= 3; j++) add("run_toggle", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      add("run_toggle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      for (int j = 5; j <= 26; j++)
         add("run_toggle", 1'b0, 1'b1, 1'b0, 1'b0, 3'(((j - 4) / 4) % 8), ((j - 4) % 4) == 0);
      // Reset at POS=5 with RUN still high; counter must restart from 0.
      add("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      for (int j = 1; j <= 3; j++) add("after_reset", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      add("after_reset", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
`endif

      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].run, vecs[i].dir, vecs[i].step);
         check({vecs[i].name, "_pos"}, i, int'(pos), int'(vecs[i].pos));
         check({vecs[i].name, "_tick"}, i, int'(tick), int'(vecs[i].tick));
      end

`ifndef SCROLL_BOUNCE_EN
      // Press latency: TICK must follow on the 3rd edge after STEP goes high.
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n = 0;
      do begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         n++;
      end while (!tick && n < 10);
      check("press_latency", 0, n, 3);
      check("press_pos", 0, int'(pos), 1);
      extra_ticks = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         if (tick) extra_ticks++;
      end
      check("press_single", 0, extra_ticks, 0);
      check("press_pos_hold", 0, int'(pos), 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
